ram1k8_arbiter: RTL and testbench
=================================

# ram1k8_arbiter

Two-port round-robin arbiter and sequencer for a single 1024x8 RAM_8K_BLK instance. It shares the RAM's one write port and one read port between requesters A and B, granting one access per cycle. It runs a zero-fill clear sequence after reset or on command. It sits between client logic and the RAM. The RAM's WClk and RClk are both tied to Clk at the parent level.

## Interface
Parameters:
- ADDR_W, 10, address width; the RAM depth is 2**ADDR_W.
- DATA_W, 8, data width.
- CLEAR_ON_RESET, 1; when 1, the block zero-fills the RAM after reset release; when 0, it starts directly in RUN.

Ports:
- Clk  in  1  single clock for the arbiter and the RAM (WClk and RClk).
- Rst_n  in  1  asynchronous, active-low reset.
- A_Req  in  1  request from A; held high until A_Gnt.
- A_Wr  in  1  1 = write, 0 = read; valid with A_Req.
- A_Addr  in  ADDR_W  access address.
- A_WD  in  DATA_W  write data.
- A_Gnt  out  1  one-cycle grant pulse.
- A_RD_Vld  out  1  one-cycle pulse; A_RD is valid in that cycle.
- A_RD  out  DATA_W  read data, wired to RD_In.
- B_Req, B_Wr, B_Addr, B_WD, B_Gnt, B_RD_Vld, B_RD: identical to the A_* ports, for requester B.
- Clr_Req  in  1  pulse that starts a clear sequence; ignored while Busy=1.
- Busy  out  1  high while a clear sequence is running.
- WA  out  ADDR_W  RAM write address (registered).
- RA  out  ADDR_W  RAM read address (registered).
- WD  out  DATA_W  RAM write data (registered).
- WEN  out  1  RAM write enable, active high (registered).
- WClk_En  out  1  RAM write-clock enable (registered).
- RClk_En  out  1  RAM read-clock enable (registered).
- RD_In  in  DATA_W  RAM read data.

## Operation
- States:
  - CLEAR: zero-fill sequence.
  - RUN: normal arbitration.
- Reset state: CLEAR if CLEAR_ON_RESET=1, else RUN.
- CLEAR behaviour:
  - A 10-bit counter Cnt runs from 0 to 1023.
  - Each cycle the block drives WA=Cnt, WD=0, WEN=1, WClk_En=1, then increments Cnt.
  - After writing address 1023, the block goes to RUN and Cnt returns to 0.
  - No grants are issued. Pending Req lines stay pending; they are not dropped.
- RUN, Clr_Req=1: the block enters CLEAR with Cnt=0. Clr_Req has priority over any pending request in that cycle.
- RUN arbitration:
  - Eligible requester = Req high and its Gnt not high in the current cycle. This masks the requester's held Req during its grant cycle.
  - If only one requester is eligible, it wins.
  - If both are eligible, the winner is the requester not granted most recently. The Last pointer resets to B, so A wins the first tie.
- Granted write: WA=Addr, WD=WD, WEN=1, WClk_En=1, RClk_En=0.
- Granted read: RA=Addr, RClk_En=1, WEN=0, WClk_En=0. The block records which requester owns the in-flight read.
- Idle cycle: WEN, WClk_En and RClk_En are all 0. WA, RA and WD hold their last values.
- Read data: A_RD and B_RD are both RD_In. Only the owner's RD_Vld pulses.
- Reset values:
  - All Gnt and RD_Vld outputs: 0.
  - WEN, WClk_En, RClk_En: 0.
  - WA, RA, WD: 0.
  - Cnt: 0.
  - Busy: CLEAR_ON_RESET.
- Reset mid-operation aborts everything. The block re-enters its reset state, and any in-flight RD_Vld is not produced.

## Timing
- Request path: Req sampled high at edge N gives Gnt high and the RAM control outputs driven in cycle N+1. The write lands at the end of cycle N+1.
- Read latency: the read is granted in cycle N+1. RD_Vld and valid RD appear in cycle N+2 (2 cycles from the sampling edge).
- Throughput:
  - One RAM access per cycle overall.
  - A single requester gets at most one grant every 2 cycles, because of the Req mask.
  - With both requesting continuously, grants alternate A,B,A,B every cycle.
- Read after write: a write granted in cycle k followed by a read of the same address granted in k+1 returns the new data.
- Busy rises in the cycle after the Clr_Req edge. It stays high for 1024 cycles, i.e. exactly the cycles with clear writes active. It falls in the cycle after the address-1023 write.
- A request may be granted in the first cycle after Busy falls.
- A read granted just before Clr_Req still produces its RD_Vld, in the first CLEAR cycle.

## Test plan
- CLEAR_ON_RESET=1, Rst_n released:
  - Busy=1 for 1024 cycles.
  - WA steps 0..1023 with WD=0 and WEN=1.
  - A_Req raised during the clear receives A_Gnt in the first RUN cycle.
- A writes 0xA5 to 0x3FF, then reads 0x3FF:
  - A_Gnt one cycle after each request.
  - A_RD_Vld two cycles after the read request, with A_RD=0xA5.
- A_Req and B_Req held continuously from reset with distinct addresses:
  - Grants alternate A,B,A,B, starting with A.
  - Never two grants in the same cycle.
  - No gaps.
- Clr_Req pulsed while B holds a read request:
  - Clear runs for 1024 cycles; B_Gnt is withheld.
  - B is granted after Busy falls, and B_RD=0x00.
- Rst_n asserted at clear address 500:
  - All outputs return to their reset values immediately.
  - After release, the clear restarts at WA=0.
- CLEAR_ON_RESET=0:
  - Busy=0 from reset.
  - A_Req at the first edge after release gives A_Gnt in the next cycle.

Source files
------------

// File: rtl/ram1k8_arbiter.sv
// ram1k8_arbiter: two-requester round-robin arbiter and zero-fill sequencer
// in front of a single 1024x8 RAM_8K_BLK. One RAM access is issued per
// cycle. All RAM controls are registered. Read data returns two cycles after
// the request is sampled.
module ram1k8_arbiter #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst_n,

    input  logic              A_Req,
    input  logic              A_Wr,
    input  logic [ADDR_W-1:0] A_Addr,
    input  logic [DATA_W-1:0] A_WD,
    output logic              A_Gnt,
    output logic              A_RD_Vld,
    output logic [DATA_W-1:0] A_RD,

    input  logic              B_Req,
    input  logic              B_Wr,
    input  logic [ADDR_W-1:0] B_Addr,
    input  logic [DATA_W-1:0] B_WD,
    output logic              B_Gnt,
    output logic              B_RD_Vld,
    output logic [DATA_W-1:0] B_RD,

    input  logic              Clr_Req,
    output logic              Busy,

    output logic [ADDR_W-1:0] WA,
    output logic [ADDR_W-1:0] RA,
    output logic [DATA_W-1:0] WD,
    output logic              WEN,
    output logic              WClk_En,
    output logic              RClk_En,
    input  logic [DATA_W-1:0] RD_In
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam state_t            RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = {ADDR_W{1'b1}};

    // Requester 0 is A, requester 1 is B.
    logic [1:0]        req;
    logic [1:0]        wr;
    logic [ADDR_W-1:0] addr [2];
    logic [DATA_W-1:0] wdat [2];
    logic [1:0]        elig;

    assign req     = {B_Req, A_Req};
    assign wr      = {B_Wr, A_Wr};
    assign addr[0] = A_Addr;
    assign addr[1] = B_Addr;
    assign wdat[0] = A_WD;
    assign wdat[1] = B_WD;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        rd_vld_q, rd_vld_d;
    logic              last_q, last_d;
    logic              rd_owner_q, rd_owner_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [ADDR_W-1:0] ra_q, ra_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic              wen_q, wen_d;
    logic              wclk_en_q, wclk_en_d;
    logic              rclk_en_q, rclk_en_d;

    logic              win_vld;
    logic              win_idx;
    logic              clr_go;
    logic [ADDR_W-1:0] clr_addr;

    // A requester whose grant is showing this cycle still has its Req held,
    // so it is masked. The read-valid pulse follows the RAM read enable by
    // one cycle and goes only to the requester that owns the read.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        localparam bit IDX = (gi == 1);
        assign elig[gi]     = req[gi] & ~gnt_q[gi];
        assign rd_vld_d[gi] = rclk_en_q & (rd_owner_q == IDX);
    end

    // Round-robin choice: a lone eligible requester wins; on a tie the one
    // not granted most recently wins.
    always_comb begin
        win_vld = |elig;
        win_idx = 1'b0;
        if (elig == 2'b11) begin
            win_idx = ~last_q;
        end else begin
            win_idx = elig[1];
        end
    end

    // Next-state and registered RAM controls. A clear step (ongoing or just
    // commanded) always pre-empts arbitration; pending requests simply wait.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_d     = 1'b0;
        gnt_d      = 2'b00;
        last_d     = last_q;
        rd_owner_d = rd_owner_q;
        wa_d       = wa_q;
        ra_d       = ra_q;
        wd_d       = wd_q;
        wen_d      = 1'b0;
        wclk_en_d  = 1'b0;
        rclk_en_d  = 1'b0;
        clr_go     = 1'b0;
        clr_addr   = cnt_q;

        if (state_q == ST_CLEAR) begin
            clr_go = 1'b1;
        end else if (Clr_Req && !busy_q) begin
            // The command edge already issues the write to address 0 so
            // that Busy and the clear writes cover the same cycles.
            clr_go   = 1'b1;
            clr_addr = '0;
        end

        if (clr_go) begin
            wa_d      = clr_addr;
            wd_d      = '0;
            wen_d     = 1'b1;
            wclk_en_d = 1'b1;
            busy_d    = 1'b1;
            if (clr_addr == LAST_ADDR) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end else begin
                state_d = ST_CLEAR;
                cnt_d   = clr_addr + 1'b1;
            end
        end else if (win_vld) begin
            gnt_d[win_idx] = 1'b1;
            last_d         = win_idx;
            if (wr[win_idx]) begin
                wa_d      = addr[win_idx];
                wd_d      = wdat[win_idx];
                wen_d     = 1'b1;
                wclk_en_d = 1'b1;
            end else begin
                ra_d       = addr[win_idx];
                rclk_en_d  = 1'b1;
                rd_owner_d = win_idx;
            end
        end
    end

    // State and output registers; reset aborts any in-flight read.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= RESET_STATE;
            cnt_q      <= '0;
            busy_q     <= CLEAR_ON_RESET;
            gnt_q      <= 2'b00;
            rd_vld_q   <= 2'b00;
            last_q     <= 1'b1;
            rd_owner_q <= 1'b0;
            wa_q       <= '0;
            ra_q       <= '0;
            wd_q       <= '0;
            wen_q      <= 1'b0;
            wclk_en_q  <= 1'b0;
            rclk_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            gnt_q      <= gnt_d;
            rd_vld_q   <= rd_vld_d;
            last_q     <= last_d;
            rd_owner_q <= rd_owner_d;
            wa_q       <= wa_d;
            ra_q       <= ra_d;
            wd_q       <= wd_d;
            wen_q      <= wen_d;
            wclk_en_q  <= wclk_en_d;
            rclk_en_q  <= rclk_en_d;
        end
    end

    assign A_Gnt    = gnt_q[0];
    assign B_Gnt    = gnt_q[1];
    assign A_RD_Vld = rd_vld_q[0];
    assign B_RD_Vld = rd_vld_q[1];
    assign A_RD     = RD_In;
    assign B_RD     = RD_In;
    assign Busy     = busy_q;
    assign WA       = wa_q;
    assign RA       = ra_q;
    assign WD       = wd_q;
    assign WEN      = wen_q;
    assign WClk_En  = wclk_en_q;
    assign RClk_En  = rclk_en_q;

endmodule

// File: tb/tb_ram1k8_arbiter.sv
// Bench for ram1k8_arbiter: directed stimulus with a RAM model, grant and
// read-data scoreboards, plus a second instance built without reset clear.
module tb_ram1k8_arbiter;

    logic       Clk;
    logic       Rst_n;
    logic       A_Req, A_Wr, A_Gnt, A_RD_Vld;
    logic [9:0] A_Addr;
    logic [7:0] A_WD, A_RD;
    logic       B_Req, B_Wr, B_Gnt, B_RD_Vld;
    logic [9:0] B_Addr;
    logic [7:0] B_WD, B_RD;
    logic       Clr_Req, Busy, WEN, WClk_En, RClk_En;
    logic [9:0] WA, RA;
    logic [7:0] WD, ram_rd;

    // second instance, CLEAR_ON_RESET = 0
    logic       z_A_Req, z_A_Wr, z_A_Gnt, z_A_RD_Vld;
    logic [9:0] z_A_Addr;
    logic [7:0] z_A_WD, z_A_RD;
    logic       z_B_Req, z_B_Wr, z_B_Gnt, z_B_RD_Vld;
    logic [9:0] z_B_Addr;
    logic [7:0] z_B_WD, z_B_RD;
    logic       z_Clr_Req, z_Busy, z_WEN, z_WClk_En, z_RClk_En;
    logic [9:0] z_WA, z_RA;
    logic [7:0] z_WD, z_RD_In;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int who;
        int cyc;
        int data;
    } exp_t;
    exp_t exp_gnt[$];
    exp_t exp_rd[$];

    ram1k8_arbiter #(.ADDR_W(10), .DATA_W(8), .CLEAR_ON_RESET(1'b1)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .A_Req(A_Req), .A_Wr(A_Wr), .A_Addr(A_Addr), .A_WD(A_WD),
        .A_Gnt(A_Gnt), .A_RD_Vld(A_RD_Vld), .A_RD(A_RD),
        .B_Req(B_Req), .B_Wr(B_Wr), .B_Addr(B_Addr), .B_WD(B_WD),
        .B_Gnt(B_Gnt), .B_RD_Vld(B_RD_Vld), .B_RD(B_RD),
        .Clr_Req(Clr_Req), .Busy(Busy),
        .WA(WA), .RA(RA), .WD(WD), .WEN(WEN), .WClk_En(WClk_En),
        .RClk_En(RClk_En), .RD_In(ram_rd)
    );

    ram1k8_arbiter #(.ADDR_W(10), .DATA_W(8), .CLEAR_ON_RESET(1'b0)) dut0 (
        .Clk(Clk), .Rst_n(Rst_n),
        .A_Req(z_A_Req), .A_Wr(z_A_Wr), .A_Addr(z_A_Addr), .A_WD(z_A_WD),
        .A_Gnt(z_A_Gnt), .A_RD_Vld(z_A_RD_Vld), .A_RD(z_A_RD),
        .B_Req(z_B_Req), .B_Wr(z_B_Wr), .B_Addr(z_B_Addr), .B_WD(z_B_WD),
        .B_Gnt(z_B_Gnt), .B_RD_Vld(z_B_RD_Vld), .B_RD(z_B_RD),
        .Clr_Req(z_Clr_Req), .Busy(z_Busy),
        .WA(z_WA), .RA(z_RA), .WD(z_WD), .WEN(z_WEN), .WClk_En(z_WClk_En),
        .RClk_En(z_RClk_En), .RD_In(z_RD_In)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // RAM_8K_BLK model: synchronous write and registered read on Clk.
    // Contents start as 0xEE so that the zero-fill is observable.
    logic [7:0] mem [1024];
    logic       mem_init = 1'b0;
    always @(posedge Clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'hEE;
            mem_init <= 1'b1;
        end else begin
            if (WEN && WClk_En) mem[WA] <= WD;
            if (RClk_En) ram_rd <= mem[RA];
        end
    end

    function automatic void chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endfunction

    task automatic push_gnt(input int who, input int c);
        exp_t e;
        e.who = who; e.cyc = c; e.data = 0;
        exp_gnt.push_back(e);
    endtask

    task automatic push_rd(input int who, input int c, input int d);
        exp_t e;
        e.who = who; e.cyc = c; e.data = d;
        exp_rd.push_back(e);
    endtask

    // Monitor: one line per observed grant / read return, checked against
    // the head of the matching expectation queue.
    always @(negedge Clk) begin : mon
        exp_t e;
        if (A_Gnt || B_Gnt) begin
            chk("dual_gnt", int'(A_Gnt & B_Gnt), 0);
            $display("cycle %0d: grant %s", cyc, A_Gnt ? "A" : "B");
            if (exp_gnt.size() == 0) begin
                chk("gnt_expected", exp_gnt.size(), 1);
            end else begin
                e = exp_gnt.pop_front();
                chk("gnt_who", B_Gnt ? 1 : 0, e.who);
                chk("gnt_cyc", cyc, e.cyc);
            end
        end
        if (A_RD_Vld || B_RD_Vld) begin
            chk("dual_rd_vld", int'(A_RD_Vld & B_RD_Vld), 0);
            $display("cycle %0d: read data %s = 0x%02h", cyc, A_RD_Vld ? "A" : "B",
                     A_RD_Vld ? A_RD : B_RD);
            if (exp_rd.size() == 0) begin
                chk("rd_expected", exp_rd.size(), 1);
            end else begin
                e = exp_rd.pop_front();
                chk("rd_who", B_RD_Vld ? 1 : 0, e.who);
                chk("rd_cyc", cyc, e.cyc);
                chk("rd_data", int'(A_RD_Vld ? A_RD : B_RD), e.data);
            end
        end
    end

    // Raise a request at the current negedge and hold it until its grant.
    task automatic do_req(input int who, input logic wr, input logic [9:0] addr,
                          input logic [7:0] wd);
        int got;
        if (who == 0) begin
            A_Req = 1'b1; A_Wr = wr; A_Addr = addr; A_WD = wd;
        end else begin
            B_Req = 1'b1; B_Wr = wr; B_Addr = addr; B_WD = wd;
        end
        got = 0;
        for (int n = 0; n < 2000 && got == 0; n++) begin
            @(negedge Clk);
            if ((who == 0 && A_Gnt) || (who == 1 && B_Gnt)) got = 1;
        end
        if (who == 0) A_Req = 1'b0;
        else B_Req = 1'b0;
        chk("req_granted", got, 1);
    endtask

    // Single access with no contention: grant next cycle, data one later.
    task automatic access(input int who, input logic wr, input logic [9:0] addr,
                          input logic [7:0] wd, input logic [7:0] exp_data);
        push_gnt(who, cyc + 1);
        if (!wr) push_rd(who, cyc + 2, int'(exp_data));
        do_req(who, wr, addr, wd);
        @(negedge Clk);
    endtask

    initial begin
        int r;
        int errs;
        int busy_cnt;
        int n;

        Rst_n = 1'b0; Clr_Req = 1'b0;
        A_Req = 0; A_Wr = 0; A_Addr = '0; A_WD = '0;
        B_Req = 0; B_Wr = 0; B_Addr = '0; B_WD = '0;
        z_A_Req = 0; z_A_Wr = 0; z_A_Addr = '0; z_A_WD = '0;
        z_B_Req = 0; z_B_Wr = 0; z_B_Addr = '0; z_B_WD = '0;
        z_Clr_Req = 0; z_RD_In = '0;

        // ---- reset values
        repeat (3) @(negedge Clk);
        chk("rst_busy", int'(Busy), 1);
        chk("rst_wen", int'(WEN), 0);
        chk("rst_wclk_en", int'(WClk_En), 0);
        chk("rst_rclk_en", int'(RClk_En), 0);
        chk("rst_wa", int'(WA), 0);
        chk("rst_ra", int'(RA), 0);
        chk("rst_wd", int'(WD), 0);
        chk("rst_gnt", int'({A_Gnt, B_Gnt, A_RD_Vld, B_RD_Vld}), 0);
        chk("rst_busy_noclr", int'(z_Busy), 0);

        // ---- release: clear sequence, requests raised during the clear
        Rst_n = 1'b1;
        z_A_Req = 1'b1; z_A_Wr = 1'b1; z_A_Addr = 10'h123; z_A_WD = 8'h77;
        r = cyc;
        errs = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge Clk);
            if (i == 0) begin
                chk("noclr_first_gnt", int'(z_A_Gnt), 1);
                chk("noclr_first_wa", int'(z_WA), 'h123);
                chk("noclr_first_wen", int'(z_WEN), 1);
                z_A_Req = 1'b0;
            end
            if (i == 1) chk("noclr_single_gnt", int'(z_A_Gnt), 0);
            if (i == 5) begin
                A_Req = 1'b1; A_Wr = 1'b1; A_Addr = 10'h010; A_WD = 8'h5A;
                B_Req = 1'b1; B_Wr = 1'b1; B_Addr = 10'h020; B_WD = 8'h6B;
                for (int k = 0; k < 8; k++) push_gnt(k % 2, r + 1025 + k);
            end
            if (int'(WA) != i || !WEN || !WClk_En || WD != 8'h00 || !Busy) errs++;
        end
        chk("clear_seq_errs", errs, 0);
        @(negedge Clk);
        chk("busy_fall", int'(Busy), 0);
        chk("run_first_wa", int'(WA), 'h010);
        chk("run_first_wd", int'(WD), 'h5A);
        chk("run_first_wen", int'(WEN), 1);
        while (cyc < r + 1032) @(negedge Clk);
        A_Req = 1'b0; B_Req = 1'b0;
        repeat (3) @(negedge Clk);

        // ---- single accesses
        access(0, 1'b1, 10'h3FF, 8'hA5, 8'h00);
        access(0, 1'b0, 10'h3FF, 8'h00, 8'hA5);
        access(1, 1'b0, 10'h010, 8'h00, 8'h5A);
        access(0, 1'b0, 10'h020, 8'h00, 8'h6B);
        access(1, 1'b0, 10'h100, 8'h00, 8'h00);

        // ---- tie after B: A writes, B reads the same address one cycle later
        push_gnt(0, cyc + 1);
        push_gnt(1, cyc + 2);
        push_rd(1, cyc + 3, 'h3C);
        fork
            do_req(0, 1'b1, 10'h055, 8'h3C);
            do_req(1, 1'b0, 10'h055, 8'h00);
        join
        repeat (3) @(negedge Clk);

        // ---- read in flight, then Clr_Req while B holds a read
        push_gnt(0, cyc + 1);
        push_rd(0, cyc + 2, 'hA5);
        do_req(0, 1'b0, 10'h3FF, 8'h00);
        r = cyc;
        chk("busy_before_clr", int'(Busy), 0);
        Clr_Req = 1'b1;
        push_gnt(1, r + 1025);
        push_rd(1, r + 1026, 'h00);
        fork
            do_req(1, 1'b0, 10'h3FF, 8'h00);
        join_none
        busy_cnt = 0;
        for (int i = 0; i < 1030; i++) begin
            @(negedge Clk);
            if (i == 0) begin
                Clr_Req = 1'b0;
                chk("busy_rise", int'(Busy), 1);
                chk("clr_first_wa", int'(WA), 0);
            end
            if (Busy) busy_cnt++;
        end
        chk("busy_len", busy_cnt, 1024);
        repeat (2) @(negedge Clk);

        // ---- reset during a read grant: no read-valid may follow
        push_gnt(0, cyc + 1);
        do_req(0, 1'b0, 10'h3FF, 8'h00);
        #2 Rst_n = 1'b0;
        #1;
        chk("abort_gnt", int'(A_Gnt), 0);
        chk("abort_rclk_en", int'(RClk_En), 0);
        chk("abort_busy", int'(Busy), 1);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;

        // ---- reset at clear address 500, then restart from 0
        errs = 0;
        for (int i = 0; i <= 500; i++) begin
            @(negedge Clk);
            if (int'(WA) != i || !WEN) errs++;
        end
        chk("clear500_seq_errs", errs, 0);
        #2 Rst_n = 1'b0;
        #1;
        chk("mid_rst_wa", int'(WA), 0);
        chk("mid_rst_wen", int'(WEN), 0);
        chk("mid_rst_wclk_en", int'(WClk_En), 0);
        chk("mid_rst_busy", int'(Busy), 1);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        chk("restart_wa", int'(WA), 0);
        chk("restart_wen", int'(WEN), 1);
        n = 0;
        while (Busy && n < 1100) begin
            @(negedge Clk);
            n++;
        end
        chk("restart_done", int'(Busy), 0);

        repeat (5) @(negedge Clk);
        chk("gnt_queue_drained", exp_gnt.size(), 0);
        chk("rd_queue_drained", exp_rd.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
